// File: rtl/arm7tdmi_ptw.sv
// arm7tdmi_ptw -- ARMv4 two-level page table walker.
// Fetches one L1 descriptor and, for coarse or fine entries, one L2
// descriptor. It returns a section, large, small or tiny translation,
// or a fault with an FSR code.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   walk_req/vaddr/ttb  walk request; accepted only in IDLE
//   walk_abort          cancels an in-flight walk (TLB flush)
//   walk_busy           high in L1, L2 and DONE
//   walk_done           one-cycle completion pulse
//   walk_fault          result is a fault
//   fault_status        FSR code for a fault
//   res_*               translation result, held until the next accept
//   mem_req/mem_addr    descriptor read request, held for the whole fetch
//   mem_rdata           descriptor data
//   mem_ready           completes the fetch
//   mem_abort           bus error; only meaningful with mem_ready
module arm7tdmi_ptw #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        walk_req,
  input  logic [31:0] walk_vaddr,
  input  logic [31:0] ttb_base,
  input  logic        walk_abort,
  output logic        walk_busy,
  output logic        walk_done,
  output logic        walk_fault,
  output logic [3:0]  fault_status,
  output logic [31:0] res_paddr,
  output logic [1:0]  res_size,
  output logic [1:0]  res_ap,
  output logic [3:0]  res_domain,
  output logic        res_c,
  output logic        res_b,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_abort
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t        state;
  logic [31:0]   vaddr_q;
  logic          fine_q;   // L2 table is fine (1 KB pages allowed)
  logic [3:0]    dom_q;    // domain carried from the L1 descriptor
  logic [CW-1:0] wait_cnt;
  logic          done_q;

  // These descriptor and base bits play no part in ARMv4 translation.
  logic unused_bits;
  assign unused_bits = ^{mem_rdata[9], ttb_base[13:0]};

  logic xfer, tmo;
  assign xfer = mem_req & mem_ready;
  assign tmo  = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Abort suppresses the pulse even when it lands in the DONE cycle.
  assign walk_done = done_q & ~walk_abort;

  // Decode of the descriptor that completes this cycle.
  logic        fin, to_l2, n_fault, n_fine, n_c, n_b;
  logic [3:0]  n_fsr, n_dom;
  logic [1:0]  n_size, n_ap;
  logic [31:0] n_paddr, l2_addr;

  always_comb begin
    fin     = 1'b0;
    to_l2   = 1'b0;
    n_fault = 1'b0;
    n_fine  = 1'b0;
    n_fsr   = 4'h0;
    n_paddr = vaddr_q;
    n_size  = 2'b00;
    n_ap    = 2'b00;
    n_dom   = 4'h0;
    n_c     = 1'b0;
    n_b     = 1'b0;
    l2_addr = 32'h0;
    case (state)
      L1: begin
        if (xfer) begin
          if (mem_abort) begin
            fin = 1'b1; n_fault = 1'b1; n_fsr = 4'hC;
          end else begin
            case (mem_rdata[1:0])
              2'b00: begin
                fin = 1'b1; n_fault = 1'b1; n_fsr = 4'h5;
              end
              2'b10: begin
                fin     = 1'b1;
                n_paddr = {mem_rdata[31:20], vaddr_q[19:0]};
                n_ap    = mem_rdata[11:10];
                n_dom   = mem_rdata[8:5];
                n_c     = mem_rdata[3];
                n_b     = mem_rdata[2];
              end
              2'b01: begin
                to_l2   = 1'b1;
                n_dom   = mem_rdata[8:5];
                l2_addr = {mem_rdata[31:10], vaddr_q[19:12], 2'b00};
              end
              default: begin
                to_l2   = 1'b1;
                n_fine  = 1'b1;
                n_dom   = mem_rdata[8:5];
                l2_addr = {mem_rdata[31:12], vaddr_q[19:10], 2'b00};
              end
            endcase
          end
        end else if (tmo) begin
          fin = 1'b1; n_fault = 1'b1; n_fsr = 4'hC;
        end
      end
      L2: begin
        if (xfer) begin
          fin = 1'b1;
          if (mem_abort) begin
            n_fault = 1'b1; n_fsr = 4'hE;
          end else if (mem_rdata[1:0] == 2'b00 ||
                       (mem_rdata[1:0] == 2'b11 && !fine_q)) begin
            // Tiny pages exist only in fine tables.
            n_fault = 1'b1; n_fsr = 4'h7;
          end else begin
            n_ap  = mem_rdata[5:4];
            n_c   = mem_rdata[3];
            n_b   = mem_rdata[2];
            n_dom = dom_q;
            case (mem_rdata[1:0])
              2'b01: begin
                n_size  = 2'b01;
                n_paddr = {mem_rdata[31:16], vaddr_q[15:0]};
              end
              2'b10: begin
                n_size  = 2'b10;
                n_paddr = {mem_rdata[31:12], vaddr_q[11:0]};
              end
              default: begin
                n_size  = 2'b11;
                n_paddr = {mem_rdata[31:10], vaddr_q[9:0]};
              end
            endcase
          end
        end else if (tmo) begin
          fin = 1'b1; n_fault = 1'b1; n_fsr = 4'hE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vaddr_q      <= '0;
      fine_q       <= 1'b0;
      dom_q        <= '0;
      wait_cnt     <= '0;
      done_q       <= 1'b0;
      walk_busy    <= 1'b0;
      walk_fault   <= 1'b0;
      fault_status <= '0;
      res_paddr    <= '0;
      res_size     <= '0;
      res_ap       <= '0;
      res_domain   <= '0;
      res_c        <= 1'b0;
      res_b        <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (walk_req) begin
            state     <= L1;
            vaddr_q   <= walk_vaddr;
            mem_addr  <= {ttb_base[31:14], walk_vaddr[31:20], 2'b00};
            mem_req   <= 1'b1;
            walk_busy <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        L1, L2: begin
          if (walk_abort) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            walk_busy <= 1'b0;
          end else if (fin) begin
            state        <= DONE;
            mem_req      <= 1'b0;
            done_q       <= 1'b1;
            walk_fault   <= n_fault;
            fault_status <= n_fsr;
            res_paddr    <= n_paddr;
            res_size     <= n_size;
            res_ap       <= n_ap;
            res_domain   <= n_dom;
            res_c        <= n_c;
            res_b        <= n_b;
          end else if (to_l2) begin
            state    <= L2;
            mem_addr <= l2_addr;
            wait_cnt <= '0;
            fine_q   <= n_fine;
            dom_q    <= n_dom;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done_q    <= 1'b0;
          walk_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm7tdmi_ptw.sv
// Directed bench for arm7tdmi_ptw. The stimulus thread pushes the expected
// walk result onto a queue. A negedge monitor pops and compares an entry
// whenever walk_done is seen.
module tb_arm7tdmi_ptw;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        walk_req, walk_abort;
  logic [31:0] walk_vaddr, ttb_base;
  logic        walk_busy, walk_done, walk_fault, res_c, res_b;
  logic [3:0]  fault_status, res_domain;
  logic [31:0] res_paddr, mem_addr;
  logic [1:0]  res_size, res_ap;
  logic        mem_req;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_abort = 1'b0;

  always #5 clk = ~clk;

  arm7tdmi_ptw #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .walk_req(walk_req), .walk_vaddr(walk_vaddr),
    .ttb_base(ttb_base), .walk_abort(walk_abort), .walk_busy(walk_busy),
    .walk_done(walk_done), .walk_fault(walk_fault), .fault_status(fault_status),
    .res_paddr(res_paddr), .res_size(res_size), .res_ap(res_ap),
    .res_domain(res_domain), .res_c(res_c), .res_b(res_b), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_abort(mem_abort)
  );

  typedef struct packed {
    logic        fault;
    logic [3:0]  fsr;
    logic [31:0] pa;
    logic [1:0]  size;
    logic [1:0]  ap;
    logic [3:0]  dom;
    logic        c;
    logic        b;
  } res_t;

  typedef struct {
    string name;
    res_t  r;
    int    lat;
    int    reqc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, acc_cyc = 0, req_total = 0, req_base = 0;

  // Descriptor memory and bus behaviour knobs.
  logic [31:0] mem [logic [31:0]];
  logic        ready_on = 1'b1, abort_en = 1'b0;
  logic [31:0] abort_addr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    mem_ready = ready_on;
    mem_abort = abort_en && (mem_addr == abort_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic f, input logic [3:0] s,
                              input logic [31:0] pa, input logic [1:0] sz,
                              input logic [1:0] ap, input logic [3:0] d,
                              input logic c, input logic b, input int lat, input int rc);
    exp_t e;
    e.name = n;
    e.r    = '{fault:f, fsr:s, pa:pa, size:sz, ap:ap, dom:d, c:c, b:b};
    e.lat  = lat;
    e.reqc = rc;
    return e;
  endfunction

  // Monitor
  exp_t e_m;
  res_t act_m;
  always @(negedge clk) begin
    if (mem_req) req_total++;
    if (rst_n && walk_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_walk_done", {63'h0, walk_done}, 64'h0);
      end else begin
        e_m   = sb.pop_front();
        act_m = '{walk_fault, fault_status, res_paddr, res_size, res_ap,
                  res_domain, res_c, res_b};
        chk({e_m.name, "_result"}, 64'(act_m), 64'(e_m.r));
        chk({e_m.name, "_latency"}, 64'(cyc + 1 - acc_cyc), 64'(e_m.lat));
        chk({e_m.name, "_req_cycles"}, 64'(req_total - req_base), 64'(e_m.reqc));
        chk({e_m.name, "_mem_req_dropped"}, {63'h0, mem_req}, 64'h0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (walk_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (walk_busy) chk("walk_completion_bound", {63'h0, walk_busy}, 64'h0);
  endtask

  task automatic start_walk(input logic [31:0] va, input logic ab);
    wait_idle();
    @(negedge clk);
    walk_vaddr = va;
    walk_req   = 1'b1;
    walk_abort = ab;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    req_base   = req_total;
    walk_req   = 1'b0;
    walk_abort = 1'b0;
    walk_vaddr = 32'hFFFF_FFFF;
  endtask

  // l2a != 0: also check the L2 descriptor address one cycle into the walk.
  task automatic run(input exp_t e, input logic [31:0] va, input logic ab,
                     input logic [31:0] l2a);
    sb.push_back(e);
    start_walk(va, ab);
    chk({e.name, "_accept_busy"}, {63'h0, walk_busy}, 64'h1);
    if (l2a != 32'h0) begin
      @(posedge clk);
      #1;
      chk({e.name, "_l2_addr"}, {32'h0, mem_addr}, {32'h0, l2a});
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    walk_req   = 1'b0;
    walk_abort = 1'b0;
    walk_vaddr = 32'h0;
    ttb_base   = 32'h0001_0000;
    mem[32'h0001_048C] = 32'h8000_0C0E;  // section
    mem[32'h0001_1400] = 32'h0002_0021;  // coarse, domain 1
    mem[32'h0002_0044] = 32'h9ABC_D03E;  // small
    mem[32'h0002_0068] = 32'h4001_0031;  // large
    mem[32'h0002_0048] = 32'h1234_5003;  // tiny in coarse table
    mem[32'h0001_0000] = 32'h0003_0003;  // fine, domain 0
    mem[32'h0003_012C] = 32'hABCD_E433;  // tiny

    #12;
    chk("reset_ctrl", {56'h0, walk_busy, walk_done, walk_fault, mem_req, fault_status}, 64'h0);
    chk("reset_paddr", {32'h0, res_paddr}, 64'h0);
    chk("reset_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("reset_misc", {50'h0, res_size, res_ap, res_domain, res_c, res_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Section walk; a stray walk_req during L1 must be ignored.
    sb.push_back(mk("section", 0, 4'h0, 32'h8004_5678, 2'b00, 2'd3, 4'h0, 1, 1, 2, 1));
    start_walk(32'h1234_5678, 1'b0);
    chk("section_l1_addr", {32'h0, mem_addr}, 64'h0001_048C);
    chk("section_mem_req", {63'h0, mem_req}, 64'h1);
    walk_req   = 1'b1;
    walk_vaddr = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    walk_req = 1'b0;
    wait_idle();

    run(mk("coarse_small", 0, 4'h0, 32'h9ABC_D400, 2'b10, 2'd3, 4'h1, 1, 1, 3, 2),
        32'h5001_1400, 1'b0, 32'h0002_0044);
    run(mk("coarse_large", 0, 4'h0, 32'h4001_ABCD, 2'b01, 2'd3, 4'h1, 0, 0, 3, 2),
        32'h5001_ABCD, 1'b0, 32'h0002_0068);
    // walk_abort asserted in IDLE together with the request: no effect.
    run(mk("fine_tiny", 0, 4'h0, 32'hABCD_E405, 2'b11, 2'd3, 4'h0, 0, 0, 3, 2),
        32'h0001_2C05, 1'b1, 32'h0003_012C);
    run(mk("l1_fault", 1, 4'h5, 32'h0030_0000, 2'b00, 2'd0, 4'h0, 0, 0, 2, 1),
        32'h0030_0000, 1'b0, 32'h0);
    run(mk("tiny_in_coarse", 1, 4'h7, 32'h5001_2400, 2'b00, 2'd0, 4'h0, 0, 0, 3, 2),
        32'h5001_2400, 1'b0, 32'h0002_0048);

    abort_en   = 1'b1;
    abort_addr = 32'h0001_048C;
    run(mk("l1_bus_abort", 1, 4'hC, 32'h1234_5678, 2'b00, 2'd0, 4'h0, 0, 0, 2, 1),
        32'h1234_5678, 1'b0, 32'h0);
    abort_addr = 32'h0002_0044;
    run(mk("l2_bus_abort", 1, 4'hE, 32'h5001_1400, 2'b00, 2'd0, 4'h0, 0, 0, 3, 2),
        32'h5001_1400, 1'b0, 32'h0002_0044);
    abort_en = 1'b0;

    ready_on = 1'b0;
    run(mk("l1_timeout", 1, 4'hC, 32'h1234_5678, 2'b00, 2'd0, 4'h0, 0, 0, 256, 255),
        32'h1234_5678, 1'b0, 32'h0);
    ready_on = 1'b1;

    // walk_abort in the same cycle the L2 fetch completes.
    start_walk(32'h5001_1400, 1'b0);
    @(posedge clk);
    #1;
    walk_abort = 1'b1;
    @(posedge clk);
    #1;
    walk_abort = 1'b0;
    chk("abort_busy", {63'h0, walk_busy}, 64'h0);
    chk("abort_mem_req", {63'h0, mem_req}, 64'h0);
    repeat (2) @(negedge clk);
    run(mk("after_abort", 0, 4'h0, 32'h8004_5678, 2'b00, 2'd3, 4'h0, 1, 1, 2, 1),
        32'h1234_5678, 1'b0, 32'h0);

    // Reset in the middle of an L1 fetch.
    ready_on = 1'b0;
    start_walk(32'h1234_5678, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_mem_req", {63'h0, mem_req}, 64'h0);
    chk("midreset_busy_done", {62'h0, walk_busy, walk_done}, 64'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_on = 1'b1;
    run(mk("after_reset", 0, 4'h0, 32'h9ABC_D400, 2'b10, 2'd3, 4'h1, 1, 1, 3, 2),
        32'h5001_1400, 1'b0, 32'h0002_0044);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arm7tdmi_ptw.md
ARM7TDMI_PTW -- requirements
Module: arm7tdmi_ptw

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for mem_ready per descriptor fetch.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- walk_req  in  1  TLB-miss walk request
- walk_vaddr  in  32  virtual address to translate
- ttb_base  in  32  translation table base
- walk_abort  in  1  cancel walk (TLB flush)
- walk_busy  out  1  walk in progress
- walk_done  out  1  one-cycle completion pulse
- walk_fault  out  1  result is a fault, valid with walk_done
- fault_status  out  4  FSR code
- res_paddr  out  32  translated physical address
- res_size  out  2  00 section, 01 large, 10 small, 11 tiny
- res_ap  out  2  access permission
- res_domain  out  4  domain
- res_c, res_b  out  1 each  cacheable, bufferable
- mem_req  out  1  descriptor read request
- mem_addr  out  32  descriptor address
- mem_rdata  in  32  descriptor data
- mem_ready  in  1  transfer complete
- mem_abort  in  1  bus error, valid with mem_ready

Function
REQ-003 SHALL implement states IDLE, L1, L2, DONE.
REQ-004 walk_req SHALL be accepted only in IDLE; on accept, walk_vaddr and ttb_base are registered, state goes to L1, and walk_req is ignored in all other states.
REQ-005 In L1/L2, mem_req SHALL be held high with constant mem_addr; a transfer completes on any clock edge with mem_req=1 and mem_ready=1.
REQ-006 L1 address SHALL be {ttb_base[31:14], vaddr[31:20], 2'b00}.
REQ-007 L1 descriptor decode, on bits [1:0]:
- 00: fault 0x5.
- 10 (section): paddr {d[31:20], vaddr[19:0]}; ap d[11:10]; domain d[8:5]; c d[3]; b d[2]; size 00.
- 01 (coarse): L2 address {d[31:10], vaddr[19:12], 2'b00}.
- 11 (fine): L2 address {d[31:12], vaddr[19:10], 2'b00}.
- For 01 and 11, domain d[8:5] is retained for the result.
REQ-008 L2 descriptor decode, on bits [1:0]:
- 00: fault 0x7.
- 01 (large): paddr {d[31:16], vaddr[15:0]}.
- 10 (small): paddr {d[31:12], vaddr[11:0]}.
- 11 (tiny): paddr {d[31:10], vaddr[9:0]} in a fine table; fault 0x7 in a coarse table.
- All L2 results: ap d[5:4], c d[3], b d[2].
REQ-009 mem_abort=1 on a completing transfer SHALL produce fault 0xC in L1 and 0xE in L2.
REQ-010 A per-fetch wait counter SHALL start at 0 on each fetch; reaching TIMEOUT_CYCLES without completion SHALL produce fault 0xC (L1) or 0xE (L2) and drop mem_req.
REQ-011 DONE SHALL assert walk_done for exactly one cycle, then return to IDLE.
REQ-012 walk_fault SHALL be 1 only when a fault occurred.
REQ-013 Result outputs SHALL be valid with walk_done and held until the next accepted walk_req; on a fault, res_paddr holds walk_vaddr.
REQ-014 Latency with zero-wait memory: accept edge k; section walk_done at cycle k+2; two-level walk_done at cycle k+3.
REQ-015 walk_busy SHALL be 1 in L1, L2 and DONE.
REQ-016 walk_abort in L1/L2/DONE SHALL force IDLE next cycle with no walk_done; abort wins over a same-cycle transfer completion or DONE.
REQ-017 walk_abort in IDLE SHALL be a no-op.
REQ-018 walk_req may be accepted the cycle after DONE.

Reset
REQ-019 Asynchronous reset SHALL force IDLE and clear the wait counter; all outputs go to 0.
REQ-020 Reset mid-walk SHALL drop mem_req immediately with no walk_done.

Verification
REQ-021 Section walk:
- Stimulus: ttb 0x00010000, vaddr 0x12345678, mem_ready always 1.
- Required: mem_addr 0x0001048C; with rdata 0x80000C0E, walk_done at k+2, res_paddr 0x80045678, size 00, ap 3, c=b=1.
REQ-022 Coarse/small walk:
- Stimulus: vaddr 0x50011400; L1 at 0x00011400 returns 0x00020021; L2 at 0x00020044 returns 0x9ABCD03E.
- Required: walk_done at k+3, res_paddr 0x9ABCD400, size 10, domain 1, ap 3.
REQ-023 Coarse/large walk:
- Stimulus: vaddr 0x5001ABCD, same L1; L2 at 0x00020068 returns 0x40010031.
- Required: res_paddr 0x4001ABCD, size 01.
REQ-024 Fault cases:
- L1 descriptor 0x00000000: walk_fault=1, status 0x5.
- mem_abort on L2 fetch: status 0xE.
- mem_ready held 0: status 0xC after 255 cycles, mem_req dropped.
REQ-025 Abort and reset:
- walk_abort same cycle as L2 completion: no walk_done, IDLE next cycle.
- rst_n low mid-L1: mem_req=0 immediately.
- New walk_req after either is served normally.
